// File: rtl/slave_port_pkg.sv
// slave_port_pkg: shared FSM state encoding and sizing helpers for the serial-bus slave port.
package slave_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RFETCH,
    RLOAD,
    RDATA,
    DONE
  } state_t;

  // Larger of two sizes.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Header length when address and burst fields are shifted in parallel.
  function automatic int unsigned addr_cyc(input int unsigned addr_w, input int unsigned burst_w);
    return max_u(addr_w, burst_w);
  endfunction

endpackage

// File: rtl/slave_sipo.sv
// slave_sipo: enable-gated LSB-first serial-in/parallel-out shift register.
// q_nxt_c exposes the value q will take at the next edge.
module slave_sipo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt_c
);

  // New bits enter at the MSB so the first bit received ends up at bit 0.
  always_comb begin
    q_nxt_c = q;
    if (en) q_nxt_c = {din, q[WIDTH-1:1]};
  end

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_nxt_c;
  end

endmodule

// File: rtl/slave_port.sv
// slave_port: slave end of the serial bus; deserialises address/burst/write data,
// drives a synchronous memory port and serialises read data back to the master.
// Define SLAVE_PORT_BURST_EN to receive and honour the burst-length field.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int unsigned SLAVE_ADDR_SIZE = 12,
  parameter int unsigned WORD_SIZE       = 8,
  parameter int unsigned BURST_SIZE      = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       m_valid,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic                       addr_bus,
  input  logic                       burst_size_bus,
  input  logic                       w_data_bus,
  output logic                       s_ready,
  output logic                       s_valid,
  output logic                       r_data_bus,
  output logic                       s_done,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_we,
  output logic                       mem_re,
  input  logic [WORD_SIZE-1:0]       mem_rdata
);

`ifdef SLAVE_PORT_BURST_EN
  localparam int unsigned ADDR_CYC = addr_cyc(SLAVE_ADDR_SIZE, BURST_SIZE);
`else
  localparam int unsigned ADDR_CYC = SLAVE_ADDR_SIZE;
`endif
  localparam int unsigned CNT_W = $clog2(max_u(ADDR_CYC, WORD_SIZE));

  state_t                     state, state_nxt;
  logic                       op_rd, op_rd_nxt;
  logic [CNT_W-1:0]           bit_cnt, bit_cnt_nxt, addr_idx_c;
  logic [SLAVE_ADDR_SIZE-1:0] mem_addr_nxt, addr_nxt_c, addr_q_unused;
  logic [BURST_SIZE-1:0]      words_left, words_nxt, words_load_c;
  logic [WORD_SIZE-1:0]       rshift, rshift_nxt, wdata_nxt_unused;
  logic                       r_data_nxt, start_c, hdr_smp_c, wdata_smp_c, last_word_c;

  // Sample qualifiers kept outside the FSM block so the shifters do not loop back into it.
  assign start_c     = sel & m_valid & (read_en ^ write_en);
  assign hdr_smp_c   = sel & (((state == IDLE) & start_c) | ((state == ADDR) & m_valid));
  assign addr_idx_c  = (state == IDLE) ? '0 : bit_cnt;
  assign wdata_smp_c = sel & m_valid & (state == WDATA);
  assign last_word_c = (words_left <= BURST_SIZE'(1));

  // Address shifter; header bits past the address width are dropped.
  slave_sipo #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_sipo (
    .clk     (clk),
    .rst     (rst),
    .en      (hdr_smp_c && (32'(addr_idx_c) < SLAVE_ADDR_SIZE)),
    .din     (addr_bus),
    .q       (addr_q_unused),
    .q_nxt_c (addr_nxt_c)
  );

  // Write-data shifter; its register doubles as the memory write-data output.
  slave_sipo #(.WIDTH(WORD_SIZE)) u_wdata_sipo (
    .clk     (clk),
    .rst     (rst),
    .en      (wdata_smp_c),
    .din     (w_data_bus),
    .q       (mem_wdata),
    .q_nxt_c (wdata_nxt_unused)
  );

`ifdef SLAVE_PORT_BURST_EN
  logic [BURST_SIZE-1:0] burst_q_unused, burst_nxt_c;

  // Burst-length shifter; a zero length still moves one word.
  slave_sipo #(.WIDTH(BURST_SIZE)) u_burst_sipo (
    .clk     (clk),
    .rst     (rst),
    .en      (hdr_smp_c && (32'(addr_idx_c) < BURST_SIZE)),
    .din     (burst_size_bus),
    .q       (burst_q_unused),
    .q_nxt_c (burst_nxt_c)
  );
  assign words_load_c = (burst_nxt_c == '0) ? BURST_SIZE'(1) : burst_nxt_c;
`else
  logic burst_bus_unused;
  assign burst_bus_unused = burst_size_bus;
  assign words_load_c     = BURST_SIZE'(1);
`endif

  // Next-state and datapath updates; deselect aborts any transaction in flight.
  always_comb begin
    state_nxt    = state;
    op_rd_nxt    = op_rd;
    bit_cnt_nxt  = bit_cnt;
    mem_addr_nxt = mem_addr;
    words_nxt    = words_left;
    rshift_nxt   = rshift;
    r_data_nxt   = 1'b0;
    if ((state != IDLE) && !sel) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            op_rd_nxt   = read_en;
            bit_cnt_nxt = CNT_W'(1);
            state_nxt   = ADDR;
          end
        end
        ADDR: begin
          if (m_valid) begin
            if (bit_cnt == CNT_W'(ADDR_CYC - 1)) begin
              bit_cnt_nxt  = '0;
              mem_addr_nxt = addr_nxt_c;
              words_nxt    = words_load_c;
              state_nxt    = op_rd ? RFETCH : WDATA;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        WDATA: begin
          if (m_valid) begin
            if (bit_cnt == CNT_W'(WORD_SIZE - 1)) begin
              bit_cnt_nxt = '0;
              state_nxt   = WRITE;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (last_word_c) begin
            state_nxt = DONE;
          end else begin
            mem_addr_nxt = mem_addr + SLAVE_ADDR_SIZE'(1);
            words_nxt    = words_left - BURST_SIZE'(1);
            state_nxt    = WDATA;
          end
        end
        RFETCH: state_nxt = RLOAD;
        RLOAD: begin
          r_data_nxt  = mem_rdata[0];
          rshift_nxt  = mem_rdata >> 1;
          bit_cnt_nxt = '0;
          state_nxt   = RDATA;
        end
        RDATA: begin
          if (bit_cnt == CNT_W'(WORD_SIZE - 1)) begin
            bit_cnt_nxt = '0;
            if (last_word_c) begin
              state_nxt = DONE;
            end else begin
              mem_addr_nxt = mem_addr + SLAVE_ADDR_SIZE'(1);
              words_nxt    = words_left - BURST_SIZE'(1);
              state_nxt    = RFETCH;
            end
          end else begin
            r_data_nxt  = rshift[0];
            rshift_nxt  = rshift >> 1;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_rd      <= 1'b0;
      bit_cnt    <= '0;
      mem_addr   <= '0;
      words_left <= '0;
      rshift     <= '0;
      s_ready    <= 1'b1;
      s_valid    <= 1'b0;
      r_data_bus <= 1'b0;
      s_done     <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_rd      <= op_rd_nxt;
      bit_cnt    <= bit_cnt_nxt;
      mem_addr   <= mem_addr_nxt;
      words_left <= words_nxt;
      rshift     <= rshift_nxt;
      s_ready    <= (state_nxt == IDLE) || (state_nxt == ADDR) || (state_nxt == WDATA);
      s_valid    <= (state_nxt == RDATA);
      r_data_bus <= r_data_nxt;
      s_done     <= (state_nxt == DONE);
      mem_we     <= (state_nxt == WRITE);
      mem_re     <= (state_nxt == RFETCH);
    end
  end

endmodule
